// File: rtl/unary_add_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package   : unary_add_pkg                                              |
// | Purpose   : Shared types and constants for the unary-adder scheduler:  |
// |             FSM state encoding, phase lengths, operand/sum widths and  |
// |             the unary pulse helper.                                    |
// | Ports     : none (package)                                             |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
package unary_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // READ streams one unary slot per cycle for operands up to 3.
  localparam int READ_CYC  = 3;
  // WRITE drains up to 3 counts plus one spare cycle so the adder ends at 0.
  localparam int DRAIN_CYC = 4;
  // Operand width; also the width of the adder's internal count.
  localparam int OPW       = 2;
  localparam int SUMW      = 3;
  // Phase counter width, wide enough for the longest phase.
  localparam int PHW       = 3;

  // Unary encoding: slot k of an operand is high while k < operand.
  function automatic logic pulse_on(input logic [PHW-1:0] phase,
                                    input logic [OPW-1:0] op);
    return phase < PHW'(op);
  endfunction

endpackage
`default_nettype wire

// File: rtl/unary_add_sched_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface : unary_add_sched_if                                         |
// | Purpose   : Bundles the request fabric (req/operands/grant/response)   |
// |             and the shared unary adder bus for the scheduler.          |
// | Modports  : slave  - the scheduler (drives gnt, resp_*, add_A/B/en/rw) |
// |             master - the environment (requesters and the adder)        |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
interface unary_add_sched_if #(
  parameter int NREQ = 4
);
  import unary_add_pkg::*;

  localparam int IDW = $clog2(NREQ);

  // Request fabric
  logic [NREQ-1:0]     req;
  logic [OPW*NREQ-1:0] req_a;
  logic [OPW*NREQ-1:0] req_b;
  logic [NREQ-1:0]     gnt;
  logic                busy;
  logic                resp_valid;
  logic [IDW-1:0]      resp_id;
  logic [SUMW-1:0]     resp_sum;

  // Shared adder bus
  logic add_A;
  logic add_B;
  logic add_en;
  logic add_rw;
  logic add_dout;
  logic add_C;

  modport slave (
    input  req, req_a, req_b, add_dout, add_C,
    output gnt, busy, resp_valid, resp_id, resp_sum,
           add_A, add_B, add_en, add_rw
  );

  modport master (
    output req, req_a, req_b, add_dout, add_C,
    input  gnt, busy, resp_valid, resp_id, resp_sum,
           add_A, add_B, add_en, add_rw
  );

endinterface
`default_nettype wire

// File: rtl/unary_add_sched_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : rr_arbiter                                                 |
// | Purpose   : Combinational round-robin pick: first requester at or      |
// |             after ptr, wrapping modulo NREQ.                           |
// | Ports     : req [NREQ] in  - request levels                            |
// |             ptr [IDW]  in  - search start index (0..NREQ-1)            |
// |             gnt [NREQ] out - one-hot winner (all zero if no request)   |
// |             idx [IDW]  out - encoded winner (0 if no request)          |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IDW = $clog2(NREQ);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  logic [IDW:0]   sum_w;
  logic [IDW-1:0] cand;
  logic           found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum_w = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum_w = {1'b0, ptr} + (IDW+1)'(i);
      if (sum_w >= (IDW+1)'(NREQ)) begin
        sum_w = sum_w - (IDW+1)'(NREQ);
      end
      cand = sum_w[IDW-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/unary_add_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : unary_add_sched                                            |
// | Purpose   : Round-robin scheduler sharing one 2-bit unary adder among  |
// |             NREQ requesters. Streams operands as unary pulses (READ),  |
// |             drains the adder (WRITE), rebuilds a 3-bit sum from the    |
// |             dout pulse count and sticky carry, and answers (DONE).     |
// | Ports     : clk   in - clock                                           |
// |             rst_n in - asynchronous active-low reset (shared w/ adder) |
// |             bus   slave modport of unary_add_sched_if:                 |
// |               req/req_a/req_b in, gnt (combinational) out,             |
// |               busy/resp_valid/resp_id/resp_sum out (registered),       |
// |               add_A/add_B/add_en/add_rw out (registered),              |
// |               add_dout/add_C in                                        |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
module unary_add_sched
  import unary_add_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  unary_add_sched_if.slave bus
);

  localparam int IDW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [PHW-1:0]  phase_q, phase_d;
  logic [OPW-1:0]  op_a_q, op_a_d;
  logic [OPW-1:0]  op_b_q, op_b_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            ovf_q, ovf_d;
  logic [OPW-1:0]  ones_q, ones_d;

  logic            busy_q, busy_d;
  logic            resp_valid_q, resp_valid_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  logic [SUMW-1:0] resp_sum_q, resp_sum_d;
  logic            add_a_q, add_a_d;
  logic            add_b_q, add_b_d;
  logic            add_en_q, add_en_d;
  logic            add_rw_q, add_rw_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_idx;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req (bus.req),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Grant is the only combinational output; it can only fire while idle.
  assign bus.gnt        = (state_q == IDLE) ? arb_gnt : '0;
  assign bus.busy       = busy_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_sum   = resp_sum_q;
  assign bus.add_A      = add_a_q;
  assign bus.add_B      = add_b_q;
  assign bus.add_en     = add_en_q;
  assign bus.add_rw     = add_rw_q;

  // FSM next state, phase counter, operand latches and accumulators.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    ovf_d    = ovf_q;
    ones_d   = ones_q;

    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          op_a_d   = bus.req_a[OPW*arb_idx +: OPW];
          op_b_d   = bus.req_b[OPW*arb_idx +: OPW];
          id_d     = arb_idx;
          rr_ptr_d = (arb_idx == IDW'(NREQ-1)) ? '0 : arb_idx + IDW'(1);
          ovf_d    = 1'b0;
          ones_d   = '0;
          phase_d  = '0;
          state_d  = READ;
        end
      end

      READ: begin
        // add_C is registered in the adder, so the carry caused by slot k
        // is visible one cycle later: sample it in READ 1, READ 2, WRITE 0.
        if (phase_q != '0) begin
          ovf_d = ovf_q | bus.add_C;
        end
        if (phase_q == PHW'(READ_CYC-1)) begin
          phase_d = '0;
          state_d = WRITE;
        end else begin
          phase_d = phase_q + PHW'(1);
        end
      end

      WRITE: begin
        // dout likewise lags the drain request by one cycle.
        if (phase_q == '0) begin
          ovf_d = ovf_q | bus.add_C;
        end else begin
          ones_d = ones_q + OPW'(bus.add_dout);
        end
        if (phase_q == PHW'(DRAIN_CYC-1)) begin
          phase_d = '0;
          state_d = DONE;
        end else begin
          phase_d = phase_q + PHW'(1);
        end
      end

      DONE: begin
        // Response the fourth drain slot: the count is already empty, so
        // this sample is always 0 and the captured sum is not affected.
        ones_d  = ones_q + OPW'(bus.add_dout);
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs, computed from the next state so they line up with
  // the state they belong to.
  always_comb begin
    busy_d       = (state_d != IDLE);
    add_en_d     = (state_d == READ) || (state_d == WRITE);
    add_rw_d     = (state_d == WRITE);
    add_a_d      = (state_d == READ) && pulse_on(phase_d, op_a_d);
    add_b_d      = (state_d == READ) && pulse_on(phase_d, op_b_d);
    resp_valid_d = (state_d == DONE);
    resp_id_d    = resp_id_q;
    resp_sum_d   = resp_sum_q;
    if (state_d == DONE) begin
      // Capture on entry to DONE, including the WRITE 3 dout sample.
      resp_id_d  = id_q;
      resp_sum_d = {ovf_d, ones_d};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      id_q         <= '0;
      rr_ptr_q     <= '0;
      ovf_q        <= 1'b0;
      ones_q       <= '0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_sum_q   <= '0;
      add_a_q      <= 1'b0;
      add_b_q      <= 1'b0;
      add_en_q     <= 1'b0;
      add_rw_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      id_q         <= id_d;
      rr_ptr_q     <= rr_ptr_d;
      ovf_q        <= ovf_d;
      ones_q       <= ones_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_sum_q   <= resp_sum_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      add_en_q     <= add_en_d;
      add_rw_q     <= add_rw_d;
    end
  end

endmodule
`default_nettype wire
